// File: rtl/rx_data_receive.sv
// SpaceWire receive-side N-char delivery: RX FIFO writes, receive credit and
// FCT requests, EEP insertion on link loss, credit/overflow errors, time-codes.
module rx_data_receive #(
  parameter int CREDIT_MAX = 56,
  parameter int FCT_CHUNK  = 8
) (
  input  logic       pclk_rx,
  input  logic       reset_rx,
  input  logic       enable_rx,
  input  logic       rx_got_data,
  input  logic [8:0] rx_data_i,
  input  logic       rx_got_timecode,
  input  logic [7:0] rx_timecode_i,
  input  logic       fct_sent,
  input  logic       fifo_full,
  input  logic [6:0] fifo_free,
  output logic       fifo_wr_en,
  output logic [8:0] fifo_wr_data,
  output logic       fct_req,
  output logic [5:0] credit_cnt,
  output logic       credit_error,
  output logic       overflow_error,
  output logic       tick_out,
  output logic [7:0] time_out
);

  localparam logic [5:0] CHUNK_6     = 6'(FCT_CHUNK);
  localparam logic [6:0] CHUNK_7     = 7'(FCT_CHUNK);
  localparam logic [5:0] REQ_LIMIT_6 = 6'(CREDIT_MAX - FCT_CHUNK);
  localparam logic [8:0] EEP_CHAR    = 9'h101;

  logic       wr_en_q, wr_en_d;
  logic [8:0] wr_data_q, wr_data_d;
  logic       fct_req_q, fct_req_d;
  logic [5:0] credit_q, credit_d;
  logic       credit_err_q, credit_err_d;
  logic       overflow_q, overflow_d;
  logic       tick_q, tick_d;
  logic [7:0] time_q, time_d;
  logic       in_packet_q, in_packet_d;
  logic       pending_eep_q, pending_eep_d;

  logic       grant;
  logic       eep_write;

  always_comb begin
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    fct_req_d     = fct_req_q;
    credit_d      = credit_q;
    credit_err_d  = 1'b0;
    overflow_d    = 1'b0;
    tick_d        = 1'b0;
    time_d        = time_q;
    in_packet_d   = in_packet_q;
    pending_eep_d = pending_eep_q;

    grant     = fct_sent & fct_req_q;
    eep_write = pending_eep_q & ~fifo_full;

    // A pending EEP drains as soon as the FIFO has room, link up or not.
    if (eep_write) begin
      wr_en_d       = 1'b1;
      wr_data_d     = EEP_CHAR;
      pending_eep_d = 1'b0;
    end

    if (!enable_rx) begin
      credit_d  = '0;
      fct_req_d = 1'b0;
      if (in_packet_q) begin
        pending_eep_d = 1'b1;
        in_packet_d   = 1'b0;
      end
    end else begin
      if (rx_got_data) begin
        if (credit_q == '0) begin
          credit_err_d = 1'b1;
        end else begin
          credit_d    = credit_q - 6'd1;
          in_packet_d = ~rx_data_i[8];
          // The EEP owns the write port this cycle, so the N-char is lost.
          if (pending_eep_q || fifo_full) begin
            overflow_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = rx_data_i;
          end
        end
      end

      if (grant) begin
        credit_d = credit_d + CHUNK_6;
      end

      fct_req_d = ~grant & ~pending_eep_q & (credit_q <= REQ_LIMIT_6) &
                  (fifo_free >= ({1'b0, credit_q} + CHUNK_7));

      if (rx_got_timecode) begin
        time_d = rx_timecode_i;
        tick_d = (rx_timecode_i[5:0] == (time_q[5:0] + 6'd1));
      end
    end
  end

  always_ff @(posedge pclk_rx) begin
    if (reset_rx) begin
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      fct_req_q     <= 1'b0;
      credit_q      <= '0;
      credit_err_q  <= 1'b0;
      overflow_q    <= 1'b0;
      tick_q        <= 1'b0;
      time_q        <= '0;
      in_packet_q   <= 1'b0;
      pending_eep_q <= 1'b0;
    end else begin
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      fct_req_q     <= fct_req_d;
      credit_q      <= credit_d;
      credit_err_q  <= credit_err_d;
      overflow_q    <= overflow_d;
      tick_q        <= tick_d;
      time_q        <= time_d;
      in_packet_q   <= in_packet_d;
      pending_eep_q <= pending_eep_d;
    end
  end

  assign fifo_wr_en     = wr_en_q;
  assign fifo_wr_data   = wr_data_q;
  assign fct_req        = fct_req_q;
  assign credit_cnt     = credit_q;
  assign credit_error   = credit_err_q;
  assign overflow_error = overflow_q;
  assign tick_out       = tick_q;
  assign time_out       = time_q;

endmodule

// File: tb/tb_rx_data_receive.sv
// Scoreboard bench for rx_data_receive: directed scenarios then randomized
// traffic, checked against a behavioural model of the receive rules.
module tb_rx_data_receive;

  localparam int CMAX  = 56;
  localparam int CHUNK = 8;

  logic       pclk_rx = 1'b0;
  logic       reset_rx, enable_rx, rx_got_data, rx_got_timecode, fct_sent, fifo_full;
  logic [8:0] rx_data_i;
  logic [7:0] rx_timecode_i;
  logic [6:0] fifo_free;
  logic       fifo_wr_en, fct_req, credit_error, overflow_error, tick_out;
  logic [8:0] fifo_wr_data;
  logic [5:0] credit_cnt;
  logic [7:0] time_out;

  rx_data_receive #(.CREDIT_MAX(CMAX), .FCT_CHUNK(CHUNK)) dut (
    .pclk_rx(pclk_rx), .reset_rx(reset_rx), .enable_rx(enable_rx),
    .rx_got_data(rx_got_data), .rx_data_i(rx_data_i),
    .rx_got_timecode(rx_got_timecode), .rx_timecode_i(rx_timecode_i),
    .fct_sent(fct_sent), .fifo_full(fifo_full), .fifo_free(fifo_free),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fct_req(fct_req),
    .credit_cnt(credit_cnt), .credit_error(credit_error),
    .overflow_error(overflow_error), .tick_out(tick_out), .time_out(time_out)
  );

  always #5 pclk_rx = ~pclk_rx;

  typedef struct {
    int rst;
    int wr;
    int credit;
    int fct;
    int cerr;
    int oerr;
    int tick;
    int tim;
  } exp_t;

  exp_t exp_q[$];
  int   wdata_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference state: credit promised, outstanding FCT request, packet/EEP flags.
  int m_credit, m_fct, m_inpkt, m_pend, m_time;

  function automatic void chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  task automatic model_step(input int rst, en, gd, d, gt, tc, fs, full, free);
    exp_t e;
    int eep, granted, newc, newf, newp;
    e = '{default: 0};
    if (rst != 0) begin
      m_credit = 0; m_fct = 0; m_inpkt = 0; m_pend = 0; m_time = 0;
      e.rst = 1;
    end else begin
      eep  = (m_pend != 0 && full == 0) ? 1 : 0;
      newp = (m_pend != 0 && eep == 0) ? 1 : 0;
      if (eep != 0) begin
        e.wr = 1;
        wdata_q.push_back(257);
      end
      if (en == 0) begin
        if (m_inpkt != 0) newp = 1;
        m_inpkt = 0;
        newc = 0;
        newf = 0;
      end else begin
        granted = (fs != 0 && m_fct != 0) ? 1 : 0;
        newc = m_credit;
        if (gd != 0) begin
          if (m_credit == 0) e.cerr = 1;
          else begin
            newc = newc - 1;
            if (m_pend != 0 || full != 0) e.oerr = 1;
            else begin
              e.wr = 1;
              wdata_q.push_back(d);
            end
            m_inpkt = (d < 256) ? 1 : 0;
          end
        end
        if (granted != 0) newc = newc + CHUNK;
        newf = (granted == 0 && m_pend == 0 && m_credit <= CMAX - CHUNK &&
                free >= m_credit + CHUNK) ? 1 : 0;
        if (gt != 0) begin
          e.tick = ((tc % 64) == ((m_time + 1) % 64)) ? 1 : 0;
          m_time = tc;
        end
      end
      m_credit = newc; m_fct = newf; m_pend = newp;
    end
    e.credit = m_credit; e.fct = m_fct; e.tim = m_time;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input int rst, en, gd, d, gt, tc, fs, full, free);
    @(negedge pclk_rx);
    reset_rx = rst[0]; enable_rx = en[0]; rx_got_data = gd[0]; rx_data_i = d[8:0];
    rx_got_timecode = gt[0]; rx_timecode_i = tc[7:0]; fct_sent = fs[0];
    fifo_full = full[0]; fifo_free = free[6:0];
    model_step(rst, en, gd, d, gt, tc, fs, full, free);
  endtask

  task automatic idle(input int en, full, free);
    cycle(0, en, 0, 0, 0, 0, 0, full, free);
  endtask

  task automatic settle;
    @(posedge pclk_rx);
    #2;
  endtask

  // Monitor: one expected record per clock edge, write data from its own queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk_rx);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_en", int'(fifo_wr_en), e.wr);
        if (e.rst != 0) chk("reset_wr_data", int'(fifo_wr_data), 0);
        if (fifo_wr_en) begin
          if (wdata_q.size() > 0) chk("wr_data", int'(fifo_wr_data), wdata_q.pop_front());
          else chk("wr_data_unexpected", int'(fifo_wr_data), -1);
        end
        chk("credit_cnt", int'(credit_cnt), e.credit);
        chk("fct_req", int'(fct_req), e.fct);
        chk("credit_error", int'(credit_error), e.cerr);
        chk("overflow_error", int'(overflow_error), e.oerr);
        chk("tick_out", int'(tick_out), e.tick);
        chk("time_out", int'(time_out), e.tim);
      end
    end
  end

  initial begin
    int en, gd, d, gt, tc, fs, full, free, rst, r;
    reset_rx = 1'b1; enable_rx = 1'b0; rx_got_data = 1'b0; rx_data_i = '0;
    rx_got_timecode = 1'b0; rx_timecode_i = '0; fct_sent = 1'b0;
    fifo_full = 1'b0; fifo_free = '0;

    // Credit build-up to the 56 ceiling with seven FCTs.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 64);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 64);
    idle(1, 0, 64);
    settle();
    chk("fct_req_after_reset", int'(fct_req), 1);
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, 0, 0, 0, 0, 1, 0, 64);
      idle(1, 0, 64);
    end
    settle();
    chk("credit_max", int'(credit_cnt), 56);
    chk("fct_req_at_max", int'(fct_req), 0);

    // Eight A5 chars exhaust a credit of 8, the ninth is a credit error.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 64);
    idle(1, 0, 64);
    cycle(0, 1, 0, 0, 0, 0, 1, 0, 64);
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, 'h0A5, 0, 0, 0, 0, 64);
    settle();
    chk("credit_drained", int'(credit_cnt), 0);
    cycle(0, 1, 1, 'h0A5, 0, 0, 0, 0, 64);
    settle();
    chk("credit_error_pulse", int'(credit_error), 1);
    chk("no_write_on_credit_error", int'(fifo_wr_en), 0);

    // Credit 16, then data and fct_sent together.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 100);
    idle(1, 0, 100);
    cycle(0, 1, 0, 0, 0, 0, 1, 0, 100);
    idle(1, 0, 100);
    cycle(0, 1, 0, 0, 0, 0, 1, 0, 100);
    idle(1, 0, 100);
    cycle(0, 1, 1, 'h033, 0, 0, 1, 0, 100);
    settle();
    chk("credit_simultaneous", int'(credit_cnt), 23);

    // Link drop mid-packet with a full FIFO, then EEP once room appears.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 64);
    idle(1, 0, 64);
    cycle(0, 1, 0, 0, 0, 0, 1, 0, 64);
    cycle(0, 1, 1, 'h011, 0, 0, 0, 0, 64);
    for (int i = 0; i < 3; i++) idle(0, 1, 64);
    idle(0, 0, 64);
    settle();
    chk("eep_written", int'(fifo_wr_data), 'h101);
    idle(1, 0, 64);
    idle(1, 0, 64);

    // Time-code sequencing including the 63->0 wrap.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 64);
    cycle(0, 1, 0, 0, 1, 'h3E, 0, 0, 64);
    cycle(0, 1, 0, 0, 1, 'h3F, 0, 0, 64);
    cycle(0, 1, 0, 0, 1, 'h00, 0, 0, 64);
    settle();
    chk("tick_on_wrap", int'(tick_out), 1);
    cycle(0, 1, 0, 0, 1, 'h05, 0, 0, 64);
    settle();
    chk("time_out_final", int'(time_out), 'h05);

    // Overflow with credit 8.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 64);
    idle(1, 0, 64);
    cycle(0, 1, 0, 0, 0, 0, 1, 0, 64);
    cycle(0, 1, 1, 'h042, 0, 0, 0, 1, 64);
    settle();
    chk("overflow_pulse", int'(overflow_error), 1);
    chk("overflow_credit", int'(credit_cnt), 7);

    // Randomized traffic.
    en = 1;
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 399) == 0) ? 1 : 0;
      r    = $urandom_range(0, 99);
      if (en != 0 && r < 3) en = 0;
      else if (en == 0 && r < 30) en = 1;
      gd   = ($urandom_range(0, 99) < 45) ? 1 : 0;
      r    = $urandom_range(0, 9);
      d    = (r == 0) ? 'h100 : (r == 1) ? 'h101 : int'($urandom_range(0, 255));
      gt   = ($urandom_range(0, 99) < 10) ? 1 : 0;
      tc   = ($urandom_range(0, 1) == 0) ? (((m_time + 1) % 64) | (int'($urandom_range(0, 3)) << 6))
                                         : int'($urandom_range(0, 255));
      fs   = ($urandom_range(0, 99) < 35) ? 1 : 0;
      full = ($urandom_range(0, 99) < 15) ? 1 : 0;
      free = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(50, 127));
      cycle(rst, en, gd, d, gt, tc, fs, full, free);
    end

    idle(1, 0, 64);
    repeat (3) @(posedge pclk_rx);
    #2;
    chk("expect_queue_drained", exp_q.size(), 0);
    chk("write_queue_drained", wdata_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_data_receive.md
# rx_data_receive

Receive-side data delivery for the SpaceWire link interface (ECSS-E-ST-50-12C). It takes decoded N-chars and time-codes from the receiver decoder and writes N-chars into the RX FIFO. It maintains the receive credit count and requests FCT transmission from the transmitter when FIFO space allows. When the link drops mid-packet it inserts an EEP, and it detects credit and overflow errors.

## Interface
Parameters:
- CREDIT_MAX, 56: maximum outstanding receive credit in N-chars (7 FCTs).
- FCT_CHUNK, 8: N-chars granted per FCT sent.

Ports:
- pclk_rx  input  1  receive-side clock; all logic on rising edge.
- reset_rx  input  1  synchronous, active-high reset.
- enable_rx  input  1  link Run/Connecting qualifier; low = link down.
- rx_got_data  input  1  one-cycle strobe: decoder delivered an N-char.
- rx_data_i  input  9  N-char; bit8=1 marks control: 9'h100 EOP, 9'h101 EEP.
- rx_got_timecode  input  1  one-cycle strobe: decoder delivered a time-code.
- rx_timecode_i  input  8  time-code; [7:6] control flags, [5:0] time value.
- fct_sent  input  1  one-cycle strobe from the transmitter: requested FCT was transmitted.
- fifo_full  input  1  RX FIFO full.
- fifo_free  input  7  RX FIFO free entries (0..127).
- fifo_wr_en  output  1  RX FIFO write strobe.
- fifo_wr_data  output  9  RX FIFO write data.
- fct_req  output  1  level request to the transmitter to send one FCT.
- credit_cnt  output  6  N-chars currently promised to the far end.
- credit_error  output  1  one-cycle pulse: N-char received with credit_cnt==0.
- overflow_error  output  1  one-cycle pulse: N-char dropped because fifo_full.
- tick_out  output  1  one-cycle pulse: in-sequence time-code received.
- time_out  output  8  last received time-code.

## Operation
- Reset (reset_rx=1): all outputs 0, in_packet=0, pending_eep=0.
- N-char path: on rx_got_data with enable_rx=1:
  - credit_cnt==0: credit_error=1 next cycle, char discarded, no credit change.
  - Else credit_cnt decrements by 1.
  - If fifo_full=0: fifo_wr_en=1 and fifo_wr_data=rx_data_i next cycle.
  - If fifo_full=1: overflow_error=1, char dropped.
  - in_packet is set by a data char (bit8=0) and cleared by EOP/EEP (bit8=1), whether or not the char was written.
- FCT request: fct_req=1 when all of these hold: enable_rx=1, pending_eep=0, credit_cnt <= CREDIT_MAX-FCT_CHUNK, and fifo_free >= credit_cnt+FCT_CHUNK (compared in 7 bits).
  - fct_req is registered from the current-cycle values.
  - On fct_sent while fct_req=1: credit_cnt += FCT_CHUNK, and fct_req is forced to 0 for that next cycle, then re-evaluated.
  - fct_sent while fct_req=0 is ignored.
- Simultaneous rx_got_data (with credit > 0) and fct_sent: credit_cnt = credit_cnt + FCT_CHUNK - 1.
- Time-code: on rx_got_timecode with enable_rx=1:
  - time_out <= rx_timecode_i always.
  - tick_out=1 only if rx_timecode_i[5:0] == time_out[5:0]+1 mod 64 (63->0 is in sequence).
- Link down (enable_rx=0):
  - credit_cnt <= 0 and fct_req <= 0.
  - rx_got_data and rx_got_timecode are ignored.
  - time_out is held.
  - If in_packet=1: pending_eep <= 1, in_packet <= 0.
- Pending EEP:
  - In any cycle with pending_eep=1 and fifo_full=0, write 9'h101 (fifo_wr_en=1), and pending_eep clears on that edge.
  - This happens regardless of enable_rx.
  - While pending_eep=1 and enable_rx=1, rx_got_data is handled after the EEP: the EEP write takes priority and the N-char is treated as overflow (overflow_error=1). Credit still decrements for that N-char.
- Error pulses do not alter credit except as stated.

## Timing
- All outputs are registered; latency is 1 cycle from the input strobe to fifo_wr_en, credit_cnt update, error pulse, tick_out or time_out.
- fifo_full and fifo_free are sampled in the same cycle as the strobe.
- fifo_wr_en is at most one pulse per cycle; back-to-back rx_got_data gives back-to-back writes.
- fct_req is a level signal and stays asserted until fct_sent or until the condition fails.
- Reset mid-operation: the next edge clears everything, including pending_eep. No EEP is written on reset.

## Test plan
- Reset, enable_rx=1, fifo_free=64: fct_req=1. Send fct_sent 7 times: credit_cnt reaches 56, fct_req=0 after the 7th.
- Credit 8, send 8 data chars 8'hA5: 8 fifo_wr_en pulses with 9'h0A5, credit_cnt=0. A 9th char gives credit_error pulse, no write.
- Credit 16, rx_got_data and fct_sent in the same cycle: credit_cnt=23.
- Data 8'h11 then drop enable_rx with fifo_full=1 for 3 cycles: no write while full. Release fifo_full: single write 9'h101, and fct_req stays 0 while pending.
- Time-codes 8'h3E, 8'h3F, 8'h00, 8'h05: tick_out on 3F and 00, not on 05. time_out=8'h05 at the end.
- fifo_full=1 with credit 8, send data: overflow_error pulse, credit_cnt=7, no write.
